calc_seq: RTL and testbench

- Sequencing controller for the keypad calculator.
- Converts raw keypad strobe/keycode into single key events and maintains the entry register and accumulator.
- Drives a shared arithmetic unit through a start/done handshake and supplies the 32-bit value for the seven-segment decoders.
- Sits between the keypad scanner and the display/ALU datapath.

---
 rtl/calc_seq.sv | 331 +++++++++++++++++++++++++++++++++
 tb/tb_calc_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/calc_seq.sv
// ---------------------------------------------------------------------------
// calc_seq - sequencing controller for the keypad calculator.
//
// Turns the raw keypad strobe/keycode into single key events. Maintains the
// hex entry register and the accumulator. Drives the shared arithmetic unit
// through a start/done handshake. Supplies the value shown on the
// seven-segment display.
//
// Ports:
//   hz100       in   system clock
//   reset_n     in   asynchronous active-low reset
//   key_strobe  in   raw key-pressed level (asynchronous to hz100)
//   keycode     in   0xxxx digit, 10000 '=', 10001 'X', 10010 '+', 10011 '-'
//   alu_start   out  one-cycle request pulse to the arithmetic unit
//   alu_op      out  0 = add, 1 = subtract, held from start until done
//   alu_a       out  accumulator operand, held from start until done
//   alu_b       out  entry operand, held from start until done
//   alu_done    in   one-cycle completion pulse
//   alu_result  in   result, valid while alu_done = 1
//   disp        out  value to display
//   busy        out  ALU operation in flight
//   err         out  sticky ALU timeout flag
//   drop        out  one-cycle pulse when a key event was discarded
//
// Optional build macro CALC_SEQ_KEYQ_EN: adds a 4-entry key FIFO between the
// edge detector and the FSM. Keys pressed while the ALU is busy are then
// queued instead of discarded.
// ---------------------------------------------------------------------------
module calc_seq #(
  parameter int WIDTH       = 32,
  parameter int DIGITS      = 8,
  parameter int ALU_TIMEOUT = 15
) (
  input  logic             hz100,
  input  logic             reset_n,
  input  logic             key_strobe,
  input  logic [4:0]       keycode,
  output logic             alu_start,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] disp,
  output logic             busy,
  output logic             err,
  output logic             drop
);

  localparam int CNT_W   = $clog2(ALU_TIMEOUT + 1);
  localparam int TOP_BIT = DIGITS * 4 - 1;

  localparam logic [4:0] KEY_EQ  = 5'b10000;
  localparam logic [4:0] KEY_X   = 5'b10001;
  localparam logic [4:0] KEY_ADD = 5'b10010;
  localparam logic [4:0] KEY_SUB = 5'b10011;

  typedef enum logic [1:0] {
    ST_ENTRY,
    ST_SHOW,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  // -------------------------------------------------------------------------
  // Key strobe synchroniser and rising-edge detector.
  // sync3_q holds the previous synchronised level for the edge detector.
  // -------------------------------------------------------------------------
  logic sync1_q, sync2_q, sync3_q;
  logic key_event;

  always_ff @(posedge hz100 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= key_strobe;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign key_event = sync2_q & ~sync3_q;

  // -------------------------------------------------------------------------
  // Key delivery to the FSM: key_valid/key_code present one key per cycle,
  // and key_drop flags an event that was thrown away.
  // -------------------------------------------------------------------------
  state_t state_q, state_d;
  logic   fsm_idle;
  logic   key_valid;
  logic   [4:0] key_code;
  logic   key_drop;

  assign fsm_idle = (state_q == ST_ENTRY) || (state_q == ST_SHOW);

`ifdef CALC_SEQ_KEYQ_EN
  logic [4:0] fifo_mem_q [4];
  logic [4:0] fifo_mem_d [4];
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [2:0] count_q, count_d;
  logic       fifo_full;
  logic       enq;
  logic       deq;

  // Dequeue whenever the FSM can accept a key. Enqueue into a full FIFO is
  // still allowed when an entry leaves in the same cycle.
  always_comb begin
    fifo_full  = (count_q == 3'd4);
    deq        = (count_q != 3'd0) && fsm_idle;
    enq        = key_event && (!fifo_full || deq);
    key_valid  = deq;
    key_code   = fifo_mem_q[rd_ptr_q];
    key_drop   = key_event && !enq;
    fifo_mem_d = fifo_mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (enq) begin
      fifo_mem_d[wr_ptr_q] = keycode;
      wr_ptr_d             = wr_ptr_q + 2'd1;
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge hz100 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        fifo_mem_q[i] <= 5'd0;
      end
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      fifo_mem_q <= fifo_mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end
`else
  // Without the queue, an event that arrives while the ALU is busy is lost.
  always_comb begin
    key_valid = key_event && fsm_idle;
    key_code  = keycode;
    key_drop  = key_event && !fsm_idle;
  end
`endif

  // -------------------------------------------------------------------------
  // Calculator FSM: next-state and next-output computation.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] entry_q, entry_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             pend_op_q, pend_op_d;
  logic             pend_valid_q, pend_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             alu_start_q, alu_start_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [WIDTH-1:0] disp_q, disp_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             drop_q, drop_d;
  logic             issue_req;

  always_comb begin
    state_d      = state_q;
    entry_d      = entry_q;
    acc_d        = acc_q;
    pend_op_d    = pend_op_q;
    pend_valid_d = pend_valid_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_start_d  = 1'b0;
    drop_d       = key_drop;
    issue_req    = 1'b0;

    case (state_q)
      ST_ENTRY: begin
        if (key_valid) begin
          if (!key_code[4]) begin
            // A full entry register ignores further digits silently.
            if (entry_q[TOP_BIT -: 4] == 4'd0) begin
              entry_d = {entry_q[WIDTH-5:0], key_code[3:0]};
            end
          end else begin
            case (key_code)
              KEY_X: begin
                entry_d = entry_q >> 4;
              end
              KEY_EQ: begin
                if (pend_valid_q) begin
                  issue_req    = 1'b1;
                  pend_valid_d = 1'b0;
                end else begin
                  acc_d   = entry_q;
                  state_d = ST_SHOW;
                end
              end
              KEY_ADD, KEY_SUB: begin
                // The operator just typed becomes the pending one; the
                // previously pending operator is the one executed now.
                pend_op_d = key_code[0];
                if (pend_valid_q) begin
                  issue_req = 1'b1;
                end else begin
                  acc_d        = entry_q;
                  pend_valid_d = 1'b1;
                  entry_d      = '0;
                  state_d      = ST_SHOW;
                end
              end
              default: ;
            endcase
          end
        end
      end

      ST_SHOW: begin
        if (key_valid) begin
          if (!key_code[4]) begin
            entry_d = {{(WIDTH-4){1'b0}}, key_code[3:0]};
            err_d   = 1'b0;
            state_d = ST_ENTRY;
          end else if ((key_code == KEY_ADD) || (key_code == KEY_SUB)) begin
            pend_op_d = key_code[0];
          end
        end
      end

      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // Done is checked before the timeout so a result arriving in the
        // last allowed cycle is still accepted.
        if (alu_done) begin
          acc_d   = alu_result;
          entry_d = '0;
          state_d = ST_SHOW;
        end else if (cnt_q == CNT_W'(ALU_TIMEOUT - 1)) begin
          err_d        = 1'b1;
          acc_d        = '0;
          pend_valid_d = 1'b0;
          state_d      = ST_SHOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = ST_ENTRY;
    endcase

    // Operands and the request pulse are captured on the way into ISSUE so
    // they are already stable in the cycle alu_start is high.
    if (issue_req) begin
      state_d     = ST_ISSUE;
      alu_start_d = 1'b1;
      alu_op_d    = {1'b0, pend_op_q};
      alu_a_d     = acc_q;
      alu_b_d     = entry_q;
      cnt_d       = '0;
    end

    busy_d = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
    disp_d = (state_d == ST_SHOW) ? acc_d : entry_d;
  end

  // -------------------------------------------------------------------------
  // Calculator FSM state and registered outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge hz100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_ENTRY;
      entry_q      <= '0;
      acc_q        <= '0;
      pend_op_q    <= 1'b0;
      pend_valid_q <= 1'b0;
      cnt_q        <= '0;
      alu_start_q  <= 1'b0;
      alu_op_q     <= 2'd0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      disp_q       <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      entry_q      <= entry_d;
      acc_q        <= acc_d;
      pend_op_q    <= pend_op_d;
      pend_valid_q <= pend_valid_d;
      cnt_q        <= cnt_d;
      alu_start_q  <= alu_start_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      disp_q       <= disp_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      drop_q       <= drop_d;
    end
  end

  assign alu_start = alu_start_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign disp      = disp_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_calc_seq.sv
// ---------------------------------------------------------------------------
// tb_calc_seq - directed self-checking bench for calc_seq.
// Contains a small ALU model that answers after a programmable number of
// cycles (0 = never answers) and counts alu_start and drop pulses.
// ---------------------------------------------------------------------------
module tb_calc_seq;

  localparam logic [4:0] K_EQ  = 5'b10000;
  localparam logic [4:0] K_X   = 5'b10001;
  localparam logic [4:0] K_ADD = 5'b10010;
  localparam logic [4:0] K_SUB = 5'b10011;

  logic        hz100 = 1'b0;
  logic        reset_n = 1'b0;
  logic        key_strobe = 1'b0;
  logic [4:0]  keycode = 5'd0;
  logic        alu_start;
  logic [1:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_done = 1'b0;
  logic [31:0] alu_result = 32'd0;
  logic [31:0] disp;
  logic        busy;
  logic        err;
  logic        drop;

  int checks = 0;
  int errors = 0;

  int          alu_delay = 2;
  int          alu_wait = 0;
  logic        alu_pending = 1'b0;
  int          start_count = 0;
  int          drop_count = 0;
  logic [31:0] last_a = 32'd0;
  logic [31:0] last_b = 32'd0;
  logic [1:0]  last_op = 2'd0;

  calc_seq dut (
    .hz100      (hz100),
    .reset_n    (reset_n),
    .key_strobe (key_strobe),
    .keycode    (keycode),
    .alu_start  (alu_start),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .disp       (disp),
    .busy       (busy),
    .err        (err),
    .drop       (drop)
  );

  always #5 hz100 = ~hz100;

  // ALU model and pulse counters, evaluated on the inactive clock edge.
  always @(negedge hz100) begin
    if (alu_done) alu_done = 1'b0;
    if (alu_pending) begin
      alu_wait = alu_wait - 1;
      if (alu_wait == 0) begin
        alu_pending = 1'b0;
        alu_done    = 1'b1;
        alu_result  = (last_op == 2'd1) ? (last_a - last_b) : (last_a + last_b);
      end
    end
    if (alu_start) begin
      start_count = start_count + 1;
      last_a  = alu_a;
      last_b  = alu_b;
      last_op = alu_op;
      if (alu_delay != 0) begin
        alu_pending = 1'b1;
        alu_wait    = alu_delay;
      end
    end
    if (drop) drop_count = drop_count + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (observed !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One full key press: hold the strobe long enough to be seen, then release.
  task automatic applyStimulus(input logic [4:0] code);
    @(negedge hz100);
    keycode    = code;
    key_strobe = 1'b1;
    repeat (5) @(negedge hz100);
    key_strobe = 1'b0;
    repeat (5) @(negedge hz100);
  endtask

  // Short press (2 high, 1 low) used to pack several keys into one ALU wait.
  task automatic quickPress(input logic [4:0] code);
    keycode    = code;
    key_strobe = 1'b1;
    repeat (2) @(negedge hz100);
    key_strobe = 1'b0;
    @(negedge hz100);
  endtask

  initial begin
    repeat (3) @(negedge hz100);
    checkOutput("reset_disp", disp, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_err", {31'd0, err}, 32'd0);
    checkOutput("reset_start", {31'd0, alu_start}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge hz100);

    // Digit entry and backspace.
    applyStimulus(5'd1);
    applyStimulus(5'd2);
    applyStimulus(5'd3);
    checkOutput("entry_123", disp, 32'h123);
    applyStimulus(K_X);
    checkOutput("backspace", disp, 32'h12);

    // '=' with nothing pending copies entry to the accumulator.
    applyStimulus(K_EQ);
    checkOutput("eq_copy", disp, 32'h12);

    // Nine digits: the ninth does not fit and is ignored without a drop.
    for (int d = 1; d <= 9; d++) applyStimulus(5'(d));
    checkOutput("entry_full", disp, 32'h12345678);
    checkOutput("no_drop_full", 32'(drop_count), 32'd0);

    // 5 + 3 = 8 through the ALU.
    applyStimulus(K_EQ);
    applyStimulus(5'd5);
    applyStimulus(K_ADD);
    checkOutput("show_acc5", disp, 32'd5);
    applyStimulus(5'd3);
    checkOutput("entry_3", disp, 32'd3);
    applyStimulus(K_EQ);
    checkOutput("add_starts", 32'(start_count), 32'd1);
    checkOutput("add_a", last_a, 32'd5);
    checkOutput("add_b", last_b, 32'd3);
    checkOutput("add_op", {30'd0, last_op}, 32'd0);
    checkOutput("add_disp", disp, 32'd8);
    checkOutput("add_busy", {31'd0, busy}, 32'd0);

    // 2 - 5 wraps modulo 2^32.
    applyStimulus(5'd2);
    applyStimulus(K_SUB);
    applyStimulus(5'd5);
    applyStimulus(K_EQ);
    checkOutput("sub_op", {30'd0, last_op}, 32'd1);
    checkOutput("sub_disp", disp, 32'hFFFF_FFFD);

    // Operator keys in SHOW only replace the pending operator.
    applyStimulus(K_ADD);
    checkOutput("show_plus_op", {31'd0, dut.pend_op_q}, 32'd0);
    applyStimulus(K_SUB);
    checkOutput("show_minus_op", {31'd0, dut.pend_op_q}, 32'd1);
    checkOutput("show_no_start", 32'(start_count), 32'd2);
    checkOutput("show_disp", disp, 32'hFFFF_FFFD);

    // ALU never answers: timeout raises err and clears the accumulator.
    alu_delay = 0;
    applyStimulus(5'd4);
    applyStimulus(K_ADD);
    applyStimulus(5'd1);
    applyStimulus(K_EQ);
    checkOutput("to_busy", {31'd0, busy}, 32'd1);
    checkOutput("to_err_early", {31'd0, err}, 32'd0);
    repeat (20) @(negedge hz100);
    checkOutput("to_err", {31'd0, err}, 32'd1);
    checkOutput("to_disp", disp, 32'd0);
    checkOutput("to_idle", {31'd0, busy}, 32'd0);
    applyStimulus(5'd7);
    checkOutput("to_clear_err", {31'd0, err}, 32'd0);
    checkOutput("to_digit", disp, 32'd7);
    checkOutput("to_starts", 32'(start_count), 32'd3);

    // Set up 7 + 2 with a slow ALU, then press keys while it works.
    applyStimulus(K_ADD);
    applyStimulus(5'd2);
`ifdef CALC_SEQ_KEYQ_EN
    alu_delay = 13;
    @(negedge hz100);
    quickPress(K_EQ);
    for (int d = 1; d <= 5; d++) quickPress(5'(d));
    repeat (20) @(negedge hz100);
    checkOutput("q_drops", 32'(drop_count), 32'd1);
    checkOutput("q_disp", disp, 32'h1234);
    checkOutput("q_busy", {31'd0, busy}, 32'd0);
    checkOutput("q_starts", 32'(start_count), 32'd4);
`else
    alu_delay = 12;
    @(negedge hz100);
    keycode    = K_EQ;
    key_strobe = 1'b1;
    repeat (5) @(negedge hz100);
    key_strobe = 1'b0;
    repeat (2) @(negedge hz100);
    keycode    = 5'd9;
    key_strobe = 1'b1;
    repeat (5) @(negedge hz100);
    checkOutput("busy_drop", 32'(drop_count), 32'd1);
    checkOutput("busy_still", {31'd0, busy}, 32'd1);
    checkOutput("busy_disp", disp, 32'd2);
    key_strobe = 1'b0;
    repeat (15) @(negedge hz100);
    checkOutput("slow_disp", disp, 32'd9);
    checkOutput("slow_busy", {31'd0, busy}, 32'd0);
    checkOutput("slow_drops", 32'(drop_count), 32'd1);
    checkOutput("slow_starts", 32'(start_count), 32'd4);
`endif

    // Asynchronous reset clears outputs without a clock edge.
    @(negedge hz100);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("areset_disp", disp, 32'd0);
    checkOutput("areset_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
